// File: rtl/cdma_wr_req_splitter_if.sv
// Request/command/status bundle around the CDMA write request splitter.
// slave: splitter side; master: requester plus write-engine side.
interface cdma_wr_req_splitter_if #(
  parameter int ADDR_BITS = 34,
  parameter int LEN_BITS  = 28
);
  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_BITS-1:0] req_addr;
  logic [LEN_BITS-1:0]  req_len;
  logic                 req_ctl;
  logic                 req_done;
  logic                 busy;
  logic                 ctrl_valid;
  logic                 stat_ready;
  logic [ADDR_BITS-1:0] ctrl_addr;
  logic [LEN_BITS-1:0]  ctrl_len;
  logic                 ctrl_ctl;
  logic                 stat_done;

  modport slave (
    input  req_valid, req_addr, req_len, req_ctl,
    input  stat_ready, stat_done,
    output req_ready, req_done, busy,
    output ctrl_valid, ctrl_addr, ctrl_len, ctrl_ctl
  );

  modport master (
    output req_valid, req_addr, req_len, req_ctl,
    output stat_ready, stat_done,
    input  req_ready, req_done, busy,
    input  ctrl_valid, ctrl_addr, ctrl_len, ctrl_ctl
  );
endinterface

// File: rtl/cdma_wr_req_splitter.sv
// Splits one aligned write request into chunk-bounded engine commands.
// Ports: aclk, aresetn (async low), bus (slave: req_*, ctrl_*, stat_*).
module cdma_wr_req_splitter #(
  parameter int ADDR_BITS       = 34,
  parameter int LEN_BITS        = 28,
  parameter int DATA_BITS       = 256,
  parameter int CHUNK_BITS      = 12,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic aclk,
  input  logic aresetn,
  cdma_wr_req_splitter_if.slave bus
);

  localparam int BEAT_BITS = $clog2(DATA_BITS / 8);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);
  localparam logic [LEN_BITS:0] CHUNK =
    (LEN_BITS+1)'(1) << CHUNK_BITS;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [LEN_BITS-1:0]  rem_q, rem_d;
  logic                 ctl_q, ctl_d;
  logic                 done_q, done_d;
  logic [OW-1:0]        out_q, out_d;

  logic [LEN_BITS:0]    off;
  logic [LEN_BITS:0]    to_bnd;
  logic [LEN_BITS-1:0]  sub_len;
  logic                 xfer;
  logic                 dec;

  // Offset inside the current chunk; low beat bits are zero by alignment.
  always_comb begin
    off = '0;
    off[CHUNK_BITS-1:BEAT_BITS] = addr_q[CHUNK_BITS-1:BEAT_BITS];
    to_bnd = CHUNK - off;
    sub_len = ({1'b0, rem_q} < to_bnd) ? rem_q
                                       : to_bnd[LEN_BITS-1:0];
  end

  assign bus.ctrl_valid = (state_q == ISSUE) && (out_q < MAX_O);
  assign bus.ctrl_addr  = addr_q;
  assign bus.ctrl_len   = sub_len;
  assign bus.ctrl_ctl   = 1'b1;
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.req_done   = done_q;

  assign xfer = bus.ctrl_valid & bus.stat_ready;
  // Stray completions with nothing outstanding are dropped.
  assign dec  = bus.stat_done & (out_q != '0);

  always_comb begin
    out_d = out_q;
    unique case ({xfer, dec})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    ctl_d   = ctl_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          rem_d   = bus.req_len;
          ctl_d   = bus.req_ctl;
          state_d = (bus.req_len == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (xfer) begin
          addr_d = addr_q + ADDR_BITS'(sub_len);
          rem_d  = rem_q - sub_len;
          if (rem_q == sub_len) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_d == '0) begin
          state_d = IDLE;
          done_d  = ctl_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      ctl_q   <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      ctl_q   <= ctl_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_cdma_wr_req_splitter.sv
// Directed bench for the CDMA write request splitter.
// Engine side modelled by a capture queue and delayed stat_done pulses.
module tb_cdma_wr_req_splitter;

  localparam int AB = 34;
  localparam int LB = 28;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cdma_wr_req_splitter_if intf ();

  cdma_wr_req_splitter dut (
    .aclk(clk),
    .aresetn(rst_n),
    .bus(intf)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit auto_en = 1'b0;
  logic auto_done = 1'b0;
  logic man_done = 1'b0;
  int due[$];
  logic [AB-1:0] cap_a[$];
  logic [LB-1:0] cap_l[$];

  assign intf.stat_done = auto_done | man_done;

  always @(posedge clk) begin
    cyc++;
    if (rst_n && intf.ctrl_valid && intf.stat_ready) begin
      cap_a.push_back(intf.ctrl_addr);
      cap_l.push_back(intf.ctrl_len);
      if (auto_en) due.push_back(cyc + 10);
    end
  end

  always @(negedge clk) begin
    auto_done = 1'b0;
    if (due.size() > 0 && due[0] <= cyc) begin
      auto_done = 1'b1;
      void'(due.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic clear_caps();
    cap_a.delete();
    cap_l.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    intf.req_valid = 1'b0;
    intf.stat_ready = 1'b0;
    man_done = 1'b0;
    auto_en = 1'b0;
    due.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_caps();
  endtask

  task automatic send_req(input logic [AB-1:0] a,
                          input logic [LB-1:0] l,
                          input logic c);
    @(negedge clk);
    total++;
    if (intf.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL req_ready_pre: got %b want 1", intf.req_ready);
    end
    intf.req_valid = 1'b1;
    intf.req_addr = a;
    intf.req_len = l;
    intf.req_ctl = c;
    @(negedge clk);
    intf.req_valid = 1'b0;
  endtask

  task automatic wait_idle(output int nd, output bit to);
    nd = 0;
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (intf.req_done === 1'b1) nd++;
      if (intf.busy === 1'b0) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    intf.req_valid = 1'b0;
    intf.req_addr = '0;
    intf.req_len = '0;
    intf.req_ctl = 1'b0;
    intf.stat_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (intf.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_ready: got %b want 1", intf.req_ready);
    end
    total++;
    if (intf.busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy: got %b want 0", intf.busy);
    end
    total++;
    if (intf.req_done !== 1'b0) begin
      bad++;
      $display("FAIL rst_done: got %b want 0", intf.req_done);
    end
    total++;
    if (intf.ctrl_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid: got %b want 0", intf.ctrl_valid);
    end
    total++;
    if (intf.ctrl_ctl !== 1'b1) begin
      bad++;
      $display("FAIL ctrl_ctl: got %b want 1", intf.ctrl_ctl);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_split();
    int nd;
    bit to;
    clear_caps();
    auto_en = 1'b1;
    intf.stat_ready = 1'b1;
    send_req(34'h1000, 28'h2000, 1'b1);
    wait_idle(nd, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL split_timeout: got busy want idle");
    end
    total++;
    if (cap_a.size() != 2) begin
      bad++;
      $display("FAIL split_count: got %0d want 2", cap_a.size());
    end else begin
      total++;
      if (cap_a[0] !== 34'h1000 || cap_l[0] !== 28'h1000) begin
        bad++;
        $display("FAIL split_cmd0: got %h/%h want 1000/1000",
                 cap_a[0], cap_l[0]);
      end
      total++;
      if (cap_a[1] !== 34'h2000 || cap_l[1] !== 28'h1000) begin
        bad++;
        $display("FAIL split_cmd1: got %h/%h want 2000/1000",
                 cap_a[1], cap_l[1]);
      end
    end
    total++;
    if (nd != 1) begin
      bad++;
      $display("FAIL split_done: got %0d want 1", nd);
    end
    @(negedge clk);
    total++;
    if (intf.req_done !== 1'b0) begin
      bad++;
      $display("FAIL split_pulse: got %b want 0", intf.req_done);
    end
  endtask

  task automatic test_unaligned();
    int nd;
    bit to;
    clear_caps();
    auto_en = 1'b1;
    intf.stat_ready = 1'b1;
    send_req(34'h0F80, 28'h200, 1'b1);
    total++;
    if (intf.busy !== 1'b1 || intf.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL unal_busy: got %b/%b want 1/0",
               intf.busy, intf.req_ready);
    end
    wait_idle(nd, to);
    total++;
    if (to || nd != 1) begin
      bad++;
      $display("FAIL unal_done: got to=%0b nd=%0d want 0/1", to, nd);
    end
    total++;
    if (cap_a.size() != 2) begin
      bad++;
      $display("FAIL unal_count: got %0d want 2", cap_a.size());
    end else begin
      total++;
      if (cap_a[0] !== 34'h0F80 || cap_l[0] !== 28'h080) begin
        bad++;
        $display("FAIL unal_cmd0: got %h/%h want f80/80",
                 cap_a[0], cap_l[0]);
      end
      total++;
      if (cap_a[1] !== 34'h1000 || cap_l[1] !== 28'h180) begin
        bad++;
        $display("FAIL unal_cmd1: got %h/%h want 1000/180",
                 cap_a[1], cap_l[1]);
      end
    end
  endtask

  task automatic test_outstanding();
    int errs;
    int early;
    clear_caps();
    auto_en = 1'b0;
    intf.stat_ready = 1'b1;
    send_req(34'h0, 28'h14000, 1'b1);
    repeat (12) @(negedge clk);
    total++;
    if (cap_a.size() != 8 || intf.ctrl_valid !== 1'b0) begin
      bad++;
      $display("FAIL os_limit: got %0d/%b want 8/0",
               cap_a.size(), intf.ctrl_valid);
    end
    for (int k = 1; k <= 12; k++) begin
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (cap_a.size() != 8 + k) begin
        bad++;
        $display("FAIL os_release%0d: got %0d want %0d",
                 k, cap_a.size(), 8 + k);
      end
    end
    errs = 0;
    for (int i = 0; i < 20 && i < cap_a.size(); i++) begin
      if (cap_a[i] !== AB'(i * 32'h1000) || cap_l[i] !== 28'h1000)
        errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL os_cmds: got %0d bad cmds want 0", errs);
    end
    early = 0;
    for (int k = 0; k < 8; k++) begin
      if (intf.busy !== 1'b1) early++;
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL os_early_idle: got %0d want 0", early);
    end
    total++;
    if (intf.busy !== 1'b0 || intf.req_done !== 1'b1) begin
      bad++;
      $display("FAIL os_finish: got busy=%b done=%b want 0/1",
               intf.busy, intf.req_done);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    int nd;
    bit to;
    int errs;
    clear_caps();
    auto_en = 1'b1;
    intf.stat_ready = 1'b0;
    send_req(34'h3000, 28'h2000, 1'b1);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      if (intf.ctrl_valid !== 1'b1 || intf.ctrl_addr !== 34'h3000 ||
          intf.ctrl_len !== 28'h1000)
        errs++;
      @(negedge clk);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL stall_hold: got %0d unstable cycles want 0", errs);
    end
    intf.stat_ready = 1'b1;
    wait_idle(nd, to);
    total++;
    if (to || nd != 1 || cap_a.size() != 2) begin
      bad++;
      $display("FAIL stall_done: got to=%0b nd=%0d n=%0d want 0/1/2",
               to, nd, cap_a.size());
    end else begin
      total++;
      if (cap_a[0] !== 34'h3000 || cap_a[1] !== 34'h4000 ||
          cap_l[1] !== 28'h1000) begin
        bad++;
        $display("FAIL stall_cmds: got %h,%h want 3000,4000",
                 cap_a[0], cap_a[1]);
      end
    end
  endtask

  task automatic test_short_and_zero();
    int nd;
    bit to;
    clear_caps();
    auto_en = 1'b1;
    intf.stat_ready = 1'b1;
    send_req(34'h5020, 28'h40, 1'b0);
    wait_idle(nd, to);
    total++;
    if (to || nd != 0) begin
      bad++;
      $display("FAIL short_done: got to=%0b nd=%0d want 0/0", to, nd);
    end
    total++;
    if (cap_a.size() != 1) begin
      bad++;
      $display("FAIL short_count: got %0d want 1", cap_a.size());
    end else begin
      total++;
      if (cap_a[0] !== 34'h5020 || cap_l[0] !== 28'h40) begin
        bad++;
        $display("FAIL short_cmd: got %h/%h want 5020/40",
                 cap_a[0], cap_l[0]);
      end
    end
    clear_caps();
    send_req(34'h7000, 28'h0, 1'b1);
    total++;
    if (intf.busy !== 1'b1 || intf.req_done !== 1'b0 ||
        intf.ctrl_valid !== 1'b0) begin
      bad++;
      $display("FAIL zero_c1: got b=%b d=%b v=%b want 1/0/0",
               intf.busy, intf.req_done, intf.ctrl_valid);
    end
    @(negedge clk);
    total++;
    if (intf.busy !== 1'b0 || intf.req_done !== 1'b1) begin
      bad++;
      $display("FAIL zero_c2: got b=%b d=%b want 0/1",
               intf.busy, intf.req_done);
    end
    @(negedge clk);
    total++;
    if (intf.req_done !== 1'b0 || cap_a.size() != 0) begin
      bad++;
      $display("FAIL zero_c3: got d=%b n=%0d want 0/0",
               intf.req_done, cap_a.size());
    end
  endtask

  task automatic test_back_to_back();
    int nd;
    bit to;
    bit seen;
    clear_caps();
    auto_en = 1'b1;
    intf.stat_ready = 1'b1;
    send_req(34'h8000, 28'h40, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (intf.req_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen || intf.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready: got seen=%0b rdy=%b want 1/1",
               seen, intf.req_ready);
    end
    intf.req_valid = 1'b1;
    intf.req_addr = 34'h9000;
    intf.req_len = 28'h40;
    intf.req_ctl = 1'b1;
    @(negedge clk);
    intf.req_valid = 1'b0;
    total++;
    if (intf.busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept: got %b want 1", intf.busy);
    end
    wait_idle(nd, to);
    total++;
    if (to || nd != 1 || cap_a.size() != 2) begin
      bad++;
      $display("FAIL b2b_done: got to=%0b nd=%0d n=%0d want 0/1/2",
               to, nd, cap_a.size());
    end else begin
      total++;
      if (cap_a[1] !== 34'h9000 || cap_l[1] !== 28'h40) begin
        bad++;
        $display("FAIL b2b_cmd: got %h/%h want 9000/40",
                 cap_a[1], cap_l[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    intf.stat_ready = 1'b1;
    send_req(34'h0, 28'h14000, 1'b1);
    repeat (3) @(negedge clk);
    intf.stat_ready = 1'b0;
    total++;
    if (cap_a.size() != 3 || intf.ctrl_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: got n=%0d v=%b want 3/1",
               cap_a.size(), intf.ctrl_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (intf.ctrl_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_async: got %b want 0", intf.ctrl_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (intf.req_ready !== 1'b1 || intf.busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_idle: got r=%b b=%b want 1/0",
               intf.req_ready, intf.busy);
    end
    for (int k = 0; k < 2; k++) begin
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
    end
    clear_caps();
    intf.stat_ready = 1'b1;
    send_req(34'h0, 28'h9000, 1'b1);
    repeat (15) @(negedge clk);
    total++;
    if (cap_a.size() != 8) begin
      bad++;
      $display("FAIL mid_counter: got %0d cmds want 8", cap_a.size());
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_split();
    test_unaligned();
    test_outstanding();
    test_stall();
    test_short_and_zero();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdma_wr_req_splitter.md
Name: cdma_wr_req_splitter

Overview:
- Command front end that sits directly upstream of the aligned CDMA write engine and drives its ctrl_valid/ctrl_addr/ctrl_len/ctrl_ctl inputs.
- Accepts one large aligned write request and splits it into sub-commands that never cross a 2^CHUNK_BITS-byte boundary.
- Limits in-flight sub-commands to MAX_OUTSTANDING, counts the engine's stat_done pulses, and signals whole-request completion upstream.

Parameters:
- ADDR_BITS, 34, byte address width.
- LEN_BITS, 28, byte length width for both request and sub-command.
- DATA_BITS, 256, datapath width; addresses and lengths are multiples of DATA_BITS/8.
- CHUNK_BITS, 12, log2 of the split boundary in bytes (default 4 KB); must be greater than log2(DATA_BITS/8).
- MAX_OUTSTANDING, 8, maximum number of issued sub-commands whose stat_done has not yet been received.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready; high only in IDLE.
- req_addr  in  ADDR_BITS  start byte address, DATA_BITS/8 aligned.
- req_len  in  LEN_BITS  byte length, multiple of DATA_BITS/8.
- req_ctl  in  1  request a completion pulse for this request.
- req_done  out  1  one-cycle pulse: all sub-commands of a req_ctl=1 request have completed.
- busy  out  1  high whenever the FSM is not in IDLE.
- ctrl_valid  out  1  sub-command valid toward the write engine.
- stat_ready  in  1  write engine ready; transfer when ctrl_valid & stat_ready.
- ctrl_addr  out  ADDR_BITS  sub-command address.
- ctrl_len  out  LEN_BITS  sub-command length in bytes.
- ctrl_ctl  out  1  tied high so the engine returns stat_done for every sub-command.
- stat_done  in  1  engine completion pulse, one per sub-command.

Behaviour:
- Reset state: FSM in IDLE. req_ready=1 (IDLE), busy=0, req_done=0, ctrl_valid=0. Outstanding counter=0. ctrl_addr, ctrl_len and the address/remaining registers are don't-care.
- Request acceptance (IDLE, req_valid=1):
  - Latch cur_addr=req_addr, remaining=req_len, ctl_r=req_ctl.
  - If req_len=0: go to DRAIN. Otherwise go to ISSUE.
- Sub-command length (combinational from registers):
  - to_boundary = 2^CHUNK_BITS - cur_addr[CHUNK_BITS-1:0], computed at LEN_BITS+1 width.
  - ctrl_len = min(remaining, to_boundary). ctrl_addr = cur_addr.
- ISSUE state:
  - ctrl_valid = (outstanding < MAX_OUTSTANDING). It is first asserted the cycle after acceptance.
  - ctrl_valid is held with stable ctrl_addr/ctrl_len until stat_ready; it never deasserts without a transfer except on reset.
  - On transfer: cur_addr += ctrl_len and remaining -= ctrl_len. If remaining == ctrl_len, go to DRAIN.
- Outstanding counter:
  - Transfer only: +1. stat_done only: -1. Both in the same cycle: unchanged.
  - stat_done while the counter is 0 is ignored; the counter never wraps.
  - The counter width holds MAX_OUTSTANDING.
- DRAIN state:
  - When the next outstanding value is 0 (a simultaneous stat_done is counted), go to IDLE.
  - In that same transition, register req_done=ctl_r, so the pulse is visible the first cycle back in IDLE.
  - Zero-length request: reaches IDLE one cycle after DRAIN is entered; req_done=ctl_r.
- Back-to-back requests: a new request is accepted in the first IDLE cycle, which may coincide with the req_done pulse.
- Address arithmetic wraps modulo 2^ADDR_BITS.
- Unaligned address or length is illegal; behaviour is unspecified, and there is no runtime check in RTL.
- Reset asserted mid-operation: all state clears immediately and asynchronously. Sub-commands in flight are abandoned, and their later stat_done pulses are ignored because the counter is 0.

Test Plan:
- req_addr=0x1000, req_len=0x2000, ctl=1, stat_ready=1, stat_done 10 cycles after each command -> ctrl (0x1000,0x1000), (0x2000,0x1000); one req_done pulse after the second stat_done.
- req_addr=0x0F80, req_len=0x200 -> ctrl (0x0F80,0x080), (0x1000,0x180); busy=1 from the cycle after acceptance until return to IDLE.
- req_len=0x14000 at 0x0, stat_done held low -> exactly 8 transfers, then ctrl_valid=0. Each stat_done releases exactly one further command; 20 commands total.
- stat_ready low for 5 cycles during ISSUE -> ctrl_valid, ctrl_addr and ctrl_len remain stable; no command is dropped or duplicated.
- req_ctl=0, len=0x40 -> single command (addr,0x40); busy returns to 0 and req_done stays 0. req_len=0, ctl=1 -> no ctrl_valid; req_done pulses 2 cycles after acceptance.
- aresetn pulsed low mid-ISSUE with 3 outstanding -> ctrl_valid=0 asynchronously; after release req_ready=1, and stray stat_done pulses leave the counter at 0.
